// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 register file and interrupt front end: IRQ sync, pending latch, EPC/Cause capture, mfc0/mtc0/eret.
// Ireq trails an IRQ edge by 4 cycles; no backpressure, the controller handshakes with Iack.
module cp0_int_ctrl #(
  parameter int          N_IRQ    = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0004
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             Ireq,
  input  logic             Iack,
  input  logic             WriteEPC,
  input  logic             WriteCause,
  input  logic             sysCause,
  input  logic             WriteCp0,
  input  logic             eret,
  input  logic [4:0]       c0_addr,
  input  logic [31:0]      c0_wdata,
  input  logic [31:0]      epc_in,
  output logic [31:0]      c0_rdata,
  output logic [31:0]      epc_out,
  output logic [31:0]      vector_out
);

  logic [N_IRQ-1:0] sync1, sync2, sync_d;
  logic [7:0]       pend, im, rise, clr, hit;
  logic             ie;
  logic [2:0]       idx, winner;
  logic [4:0]       exc_code;
  logic [31:0]      epc, ebase;
  logic             wr_status, wr_cause, wr_epc, wr_ebase;

  assign wr_status = WriteCp0 && (c0_addr == 5'd12);
  assign wr_cause  = WriteCp0 && (c0_addr == 5'd13);
  assign wr_epc    = WriteCp0 && (c0_addr == 5'd14);
  assign wr_ebase  = WriteCp0 && (c0_addr == 5'd15);

  always_comb begin
    rise = '0;
    rise[N_IRQ-1:0] = sync2 & ~sync_d;
    hit = pend & im;
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hit[i]) winner = 3'(i);
    end
    // Exception entry owns pend this cycle, so a W1C from mtc0 is dropped.
    clr = '0;
    if (Iack) begin
      if (|hit) clr[winner] = 1'b1;
    end else if (wr_cause && !WriteCause) begin
      clr = c0_wdata[15:8];
    end
  end

  always_comb begin
    c0_rdata = 32'd0;
    case (c0_addr)
      5'd12:   c0_rdata = {16'd0, im, 7'd0, ie};
      5'd13:   c0_rdata = {13'd0, idx, pend, 1'b0, exc_code, 2'b00};
      5'd14:   c0_rdata = epc;
      5'd15:   c0_rdata = ebase;
      default: c0_rdata = 32'd0;
    endcase
  end

  assign epc_out    = epc;
  assign vector_out = ebase + ((exc_code == 5'd8) ? 32'd0 : ({27'd0, idx, 2'b00} + 32'd4));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_d   <= '0;
      pend     <= '0;
      Ireq     <= 1'b0;
      ie       <= 1'b0;
      im       <= '0;
      idx      <= '0;
      exc_code <= '0;
      epc      <= '0;
      ebase    <= VEC_BASE;
    end else begin
      sync1  <= irq_in;
      sync2  <= sync1;
      sync_d <= sync2;
      // Set after clear: an edge coinciding with a clear is never lost.
      pend   <= (pend & ~clr) | rise;
      Ireq   <= ie & (|hit) & ~Iack & ~WriteCause;

      if (Iack) begin
        idx      <= winner;
        exc_code <= 5'd0;
        ie       <= 1'b0;
      end else if (WriteCause && sysCause) begin
        exc_code <= 5'd8;
        ie       <= 1'b0;
      end else if (eret) begin
        ie <= 1'b1;
      end else if (wr_status) begin
        ie <= c0_wdata[0];
      end

      if (wr_status) im <= c0_wdata[15:8];

      if (WriteEPC) epc <= epc_in;
      else if (wr_epc) epc <= c0_wdata;

      if (wr_ebase) ebase <= {c0_wdata[31:2], 2'b00};
    end
  end

endmodule
